wb_arb_2: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 26 ++
 rtl/wb_arb_rr_2.sv | 30 +++
 rtl/wb_arb_2.sv | 171 +++++++++++++++++
 tb/tb_wb_arb_2.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: grant encodings
// and the tie-break rule used when both masters request at once.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    GRANT_IDLE = 2'b00,
    GRANT_M0   = 2'b01,
    GRANT_M1   = 2'b10
  } grant_t;

  // One-hot pick among requesters. On a tie, round-robin favours the master
  // that was not granted last; fixed priority always favours master 0.
  function automatic logic [1:0] rr_select(input logic [1:0] req,
                                           input logic       last,
                                           input logic       round_robin);
    logic [1:0] pick;
    case (req)
      2'b01:   pick = GRANT_M0;
      2'b10:   pick = GRANT_M1;
      2'b11:   pick = (round_robin && !last) ? GRANT_M1 : GRANT_M0;
      default: pick = GRANT_IDLE;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/wb_arb_rr_2.sv
// Two-requester priority picker. Holds the "granted most recently" flop
// and produces the one-hot winner for the current request vector.
module wb_arb_rr_2 #(
  parameter int ARB_ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant_next
);
  import wb_arb_pkg::*;

  localparam logic ROUND_ROBIN = (ARB_ROUND_ROBIN != 0);

  // 1 = master 1 was granted last, so master 0 wins the first tie.
  logic last_reg;

  assign grant_next = rr_select(req, last_reg, ROUND_ROBIN);

  // Record the winner whenever the grant register actually takes a new owner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_reg <= 1'b1;
    end else if (advance && (grant_next != GRANT_IDLE)) begin
      last_reg <= grant_next[1];
    end
  end

endmodule

// File: rtl/wb_arb_2.sv
// Two-master Wishbone arbiter sharing one slave port. A granted master keeps
// the bus until it drops CYC; an optional watchdog ends stalled strobes with ERR.
module wb_arb_2 #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SELECT_WIDTH    = DATA_WIDTH / 8,
  parameter int ARB_ROUND_ROBIN = 1,
  parameter int TIMEOUT         = 0,
  parameter int TIMEOUT_WIDTH   = $clog2(TIMEOUT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
  input  logic                    wbm0_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
  input  logic                    wbm0_stb_i,
  input  logic                    wbm0_cyc_i,
  output logic                    wbm0_ack_o,
  output logic                    wbm0_err_o,
  output logic                    wbm0_rty_o,
  input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
  input  logic                    wbm1_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
  input  logic                    wbm1_stb_i,
  input  logic                    wbm1_cyc_i,
  output logic                    wbm1_ack_o,
  output logic                    wbm1_err_o,
  output logic                    wbm1_rty_o,
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i,
  output logic                    wbs_cyc_o,
  output logic [1:0]              grant
);
  import wb_arb_pkg::*;

  grant_t          grant_reg;
  logic [1:0]      cyc_vec;
  logic [1:0]      stb_vec;
  logic [1:0]      owner_vec;
  logic [1:0]      rr_grant_next;
  logic            owner_valid;
  logic            owner_cyc;
  logic            owner_stb;
  logic            advance;
  logic            to_fire;

  assign cyc_vec     = {wbm1_cyc_i, wbm0_cyc_i};
  assign stb_vec     = {wbm1_stb_i, wbm0_stb_i};
  assign owner_vec   = {grant_reg == GRANT_M1, grant_reg == GRANT_M0};
  assign owner_valid = |owner_vec;
  assign owner_cyc   = |(owner_vec & cyc_vec);
  assign owner_stb   = |(owner_vec & stb_vec);

  // Arbitrate from idle, or in the same edge the owner releases the bus.
  // The releasing owner's cyc is already low, so the raw cyc vector is the
  // correct request set in both cases.
  assign advance = (grant_reg == GRANT_IDLE) || (owner_valid && !owner_cyc);

  wb_arb_rr_2 #(
    .ARB_ROUND_ROBIN(ARB_ROUND_ROBIN)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (cyc_vec),
    .advance   (advance),
    .grant_next(rr_grant_next)
  );

  // Grant register: hold while the owner keeps cyc, re-arbitrate otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_reg <= GRANT_IDLE;
    end else begin
      case (grant_reg)
        GRANT_IDLE, GRANT_M0, GRANT_M1: begin
          if (advance) grant_reg <= grant_t'(rr_grant_next);
        end
        default: grant_reg <= GRANT_IDLE;
      endcase
    end
  end

  assign grant = grant_reg;

  generate
    if (TIMEOUT > 0) begin : g_wdog
      logic [TIMEOUT_WIDTH-1:0] cnt_reg;
      logic                     any_resp;
      logic                     grant_change;

      assign any_resp     = wbs_ack_i | wbs_err_i | wbs_rty_i;
      assign grant_change = advance && (rr_grant_next != grant_reg);
      // Fires independently of the slave response so that wbs_stb_o never
      // depends combinationally on wbs_ack_i; an ack wins at the master side.
      assign to_fire = owner_valid && owner_cyc && owner_stb &&
                       (cnt_reg == TIMEOUT_WIDTH'(TIMEOUT - 1));

      // Count consecutive unanswered strobe cycles of the current owner.
      always_ff @(posedge clk) begin
        if (!rst) begin
          cnt_reg <= '0;
        end else if (grant_change || !owner_valid || !owner_stb || any_resp || to_fire) begin
          cnt_reg <= '0;
        end else if (owner_cyc && owner_stb) begin
          cnt_reg <= cnt_reg + TIMEOUT_WIDTH'(1);
        end
      end
    end else begin : g_no_wdog
      assign to_fire = 1'b0;
    end
  endgenerate

  // Copy the owner's request onto the slave port; drive all zeros when idle.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_we_o  = 1'b0;
    wbs_sel_o = '0;
    wbs_stb_o = 1'b0;
    wbs_cyc_o = 1'b0;
    if (owner_vec[0]) begin
      wbs_adr_o = wbm0_adr_i;
      wbs_dat_o = wbm0_dat_i;
      wbs_we_o  = wbm0_we_i;
      wbs_sel_o = wbm0_sel_i;
      wbs_stb_o = wbm0_stb_i & ~to_fire;
      wbs_cyc_o = wbm0_cyc_i;
    end else if (owner_vec[1]) begin
      wbs_adr_o = wbm1_adr_i;
      wbs_dat_o = wbm1_dat_i;
      wbs_we_o  = wbm1_we_i;
      wbs_sel_o = wbm1_sel_i;
      wbs_stb_o = wbm1_stb_i & ~to_fire;
      wbs_cyc_o = wbm1_cyc_i;
    end
  end

  // Slave responses reach the owner only; the other master sees zeros.
  logic [1:0]            ack_vec;
  logic [1:0]            err_vec;
  logic [1:0]            rty_vec;
  logic [DATA_WIDTH-1:0] dat_vec [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign ack_vec[gi] = owner_vec[gi] & wbs_ack_i;
    assign err_vec[gi] = owner_vec[gi] & (wbs_err_i | (to_fire & ~wbs_ack_i));
    assign rty_vec[gi] = owner_vec[gi] & wbs_rty_i;
    assign dat_vec[gi] = owner_vec[gi] ? wbs_dat_i : '0;
  end

  assign wbm0_ack_o = ack_vec[0];
  assign wbm0_err_o = err_vec[0];
  assign wbm0_rty_o = rty_vec[0];
  assign wbm0_dat_o = dat_vec[0];
  assign wbm1_ack_o = ack_vec[1];
  assign wbm1_err_o = err_vec[1];
  assign wbm1_rty_o = rty_vec[1];
  assign wbm1_dat_o = dat_vec[1];

endmodule

// File: tb/tb_wb_arb_2.sv
// Bench for wb_arb_2: a round-robin instance with a 4-cycle watchdog and a
// fixed-priority instance without one, driven with identical stimulus.
module tb_wb_arb_2;

  localparam logic [31:0] D = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [1:0]  m_we  = '0;
  logic [3:0]  m_sel [2];
  logic [1:0]  m_stb = '0;
  logic [1:0]  m_cyc = '0;
  logic [31:0] s_dat = D;
  logic        s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

  logic [31:0] a_m0_dat, a_m1_dat, a_wbs_adr, a_wbs_dat;
  logic        a_m0_ack, a_m0_err, a_m0_rty, a_m1_ack, a_m1_err, a_m1_rty;
  logic        a_wbs_we, a_wbs_stb, a_wbs_cyc;
  logic [3:0]  a_wbs_sel;
  logic [1:0]  a_grant;
  logic [31:0] b_m0_dat, b_m1_dat, b_wbs_adr, b_wbs_dat;
  logic        b_m0_ack, b_m0_err, b_m0_rty, b_m1_ack, b_m1_err, b_m1_rty;
  logic        b_wbs_we, b_wbs_stb, b_wbs_cyc;
  logic [3:0]  b_wbs_sel;
  logic [1:0]  b_grant;

  always #5 clk = ~clk;

  wb_arb_2 #(.ARB_ROUND_ROBIN(1), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst),
    .wbm0_adr_i(m_adr[0]), .wbm0_dat_i(m_dat[0]), .wbm0_dat_o(a_m0_dat), .wbm0_we_i(m_we[0]),
    .wbm0_sel_i(m_sel[0]), .wbm0_stb_i(m_stb[0]), .wbm0_cyc_i(m_cyc[0]),
    .wbm0_ack_o(a_m0_ack), .wbm0_err_o(a_m0_err), .wbm0_rty_o(a_m0_rty),
    .wbm1_adr_i(m_adr[1]), .wbm1_dat_i(m_dat[1]), .wbm1_dat_o(a_m1_dat), .wbm1_we_i(m_we[1]),
    .wbm1_sel_i(m_sel[1]), .wbm1_stb_i(m_stb[1]), .wbm1_cyc_i(m_cyc[1]),
    .wbm1_ack_o(a_m1_ack), .wbm1_err_o(a_m1_err), .wbm1_rty_o(a_m1_rty),
    .wbs_adr_o(a_wbs_adr), .wbs_dat_i(s_dat), .wbs_dat_o(a_wbs_dat), .wbs_we_o(a_wbs_we),
    .wbs_sel_o(a_wbs_sel), .wbs_stb_o(a_wbs_stb), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
    .wbs_rty_i(s_rty), .wbs_cyc_o(a_wbs_cyc), .grant(a_grant)
  );

  wb_arb_2 #(.ARB_ROUND_ROBIN(0), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst),
    .wbm0_adr_i(m_adr[0]), .wbm0_dat_i(m_dat[0]), .wbm0_dat_o(b_m0_dat), .wbm0_we_i(m_we[0]),
    .wbm0_sel_i(m_sel[0]), .wbm0_stb_i(m_stb[0]), .wbm0_cyc_i(m_cyc[0]),
    .wbm0_ack_o(b_m0_ack), .wbm0_err_o(b_m0_err), .wbm0_rty_o(b_m0_rty),
    .wbm1_adr_i(m_adr[1]), .wbm1_dat_i(m_dat[1]), .wbm1_dat_o(b_m1_dat), .wbm1_we_i(m_we[1]),
    .wbm1_sel_i(m_sel[1]), .wbm1_stb_i(m_stb[1]), .wbm1_cyc_i(m_cyc[1]),
    .wbm1_ack_o(b_m1_ack), .wbm1_err_o(b_m1_err), .wbm1_rty_o(b_m1_rty),
    .wbs_adr_o(b_wbs_adr), .wbs_dat_i(s_dat), .wbs_dat_o(b_wbs_dat), .wbs_we_o(b_wbs_we),
    .wbs_sel_o(b_wbs_sel), .wbs_stb_o(b_wbs_stb), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
    .wbs_rty_i(s_rty), .wbs_cyc_o(b_wbs_cyc), .grant(b_grant)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [142:0] act, input logic [142:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [142:0] pk(
      input logic [1:0] g, input logic [31:0] adr, input logic [31:0] dat, input logic we,
      input logic [3:0] sel, input logic stb, input logic cyc,
      input logic [31:0] d0, input logic a0, input logic e0, input logic r0,
      input logic [31:0] d1, input logic a1, input logic e1, input logic r1);
    return {g, adr, dat, we, sel, stb, cyc, d0, a0, e0, r0, d1, a1, e1, r1};
  endfunction

  function automatic logic [142:0] act_a();
    return pk(a_grant, a_wbs_adr, a_wbs_dat, a_wbs_we, a_wbs_sel, a_wbs_stb, a_wbs_cyc,
              a_m0_dat, a_m0_ack, a_m0_err, a_m0_rty, a_m1_dat, a_m1_ack, a_m1_err, a_m1_rty);
  endfunction

  function automatic logic [142:0] act_b();
    return pk(b_grant, b_wbs_adr, b_wbs_dat, b_wbs_we, b_wbs_sel, b_wbs_stb, b_wbs_cyc,
              b_m0_dat, b_m0_ack, b_m0_err, b_m0_rty, b_m1_dat, b_m1_ack, b_m1_err, b_m1_rty);
  endfunction

  // Reference model: owner index (-1 = nobody), last winner, and how many
  // unanswered strobe cycles the owner has accumulated. k=0: RR+watchdog(4), k=1: fixed.
  int m_owner [2] = '{-1, -1};
  int m_last  [2] = '{1, 1};
  int m_stall [2] = '{0, 0};

  function automatic int cfg_to(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  function automatic bit m_fire(input int k);
    int o;
    o = m_owner[k];
    if (cfg_to(k) == 0 || o < 0) return 1'b0;
    return m_cyc[o[0]] && m_stb[o[0]] && (m_stall[k] == cfg_to(k) - 1);
  endfunction

  function automatic logic [142:0] m_expect(input int k);
    logic [1:0]  g;
    logic [31:0] adr, dat, d0, d1;
    logic        we, stb, cyc, a0, e0, r0, a1, e1, r1;
    logic [3:0]  sel;
    int          o;
    bit          f;
    g = '0; adr = '0; dat = '0; d0 = '0; d1 = '0; sel = '0;
    we = 0; stb = 0; cyc = 0; a0 = 0; e0 = 0; r0 = 0; a1 = 0; e1 = 0; r1 = 0;
    o = m_owner[k];
    f = m_fire(k);
    if (o >= 0) begin
      g[o[0]] = 1'b1;
      adr = m_adr[o[0]]; dat = m_dat[o[0]]; we = m_we[o[0]]; sel = m_sel[o[0]];
      stb = m_stb[o[0]] & !f;
      cyc = m_cyc[o[0]];
      if (o == 0) begin
        d0 = s_dat; a0 = s_ack; e0 = s_err | (f & !s_ack); r0 = s_rty;
      end else begin
        d1 = s_dat; a1 = s_ack; e1 = s_err | (f & !s_ack); r1 = s_rty;
      end
    end
    return pk(g, adr, dat, we, sel, stb, cyc, d0, a0, e0, r0, d1, a1, e1, r1);
  endfunction

  always @(posedge clk) begin : model_update
    int prev, o;
    bit f;
    for (int k = 0; k < 2; k++) begin
      f = m_fire(k);
      prev = m_owner[k];
      if (!rst) begin
        m_owner[k] = -1; m_last[k] = 1; m_stall[k] = 0;
      end else begin
        o = m_owner[k];
        if (o < 0 || !m_cyc[o[0]]) begin
          if (m_cyc == 2'b11)      m_owner[k] = (k == 0) ? 1 - m_last[k] : 0;
          else if (m_cyc[0])       m_owner[k] = 0;
          else if (m_cyc[1])       m_owner[k] = 1;
          else                     m_owner[k] = -1;
        end
        o = m_owner[k];
        if (o != prev) begin
          m_stall[k] = 0;
          if (o >= 0) m_last[k] = o;
        end else if (o < 0 || !m_stb[o[0]] || s_ack || s_err || s_rty || f) begin
          m_stall[k] = 0;
        end else begin
          m_stall[k] = m_stall[k] + 1;
        end
      end
    end
  end

  task automatic model_check();
    chk("model_rr", act_a(), m_expect(0));
    chk("model_fp", act_b(), m_expect(1));
  endtask

  task automatic drive(input logic r, input logic c0, input logic s0,
                       input logic c1, input logic s1, input logic ack);
    @(negedge clk);
    rst = r; m_cyc = {c1, c0}; m_stb = {s1, s0};
    s_ack = ack; s_err = 1'b0; s_rty = 1'b0;
    #1;
    model_check();
  endtask

  typedef struct packed {
    logic        rst, c0, s0, c1, s1, ack;
    logic [1:0]  g, fg;
    logic        wcyc, wstb;
    logic [31:0] adr;
    logic        a0;
    logic [31:0] d0;
    logic        a1;
    logic [31:0] d1;
  } vec_t;

  vec_t tbl [14];
  int   resp_pct;

  initial begin
    m_adr[0] = 32'h1000; m_adr[1] = 32'h2000;
    m_dat[0] = 32'h1111_0000; m_dat[1] = 32'h2222_0000;
    m_sel[0] = 4'hF; m_sel[1] = 4'h3;

    //            rst c0 s0 c1 s1 ack  grant  fp     wcyc wstb adr           a0 d0     a1 d1
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00, 1'b0,1'b0, 32'h0,    1'b0,32'h0, 1'b0,32'h0};
    tbl[1]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00, 1'b0,1'b0, 32'h0,    1'b0,32'h0, 1'b0,32'h0};
    tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1, 2'b01,2'b01, 1'b1,1'b1, 32'h1000, 1'b1,D,     1'b0,32'h0};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b01, 1'b0,1'b0, 32'h1000, 1'b0,D,     1'b0,32'h0};
    tbl[4]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 2'b00,2'b00, 1'b0,1'b0, 32'h0,    1'b0,32'h0, 1'b0,32'h0};
    tbl[5]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 2'b01,2'b01, 1'b1,1'b1, 32'h1000, 1'b0,D,     1'b0,32'h0};
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 2'b01,2'b01, 1'b0,1'b0, 32'h1000, 1'b0,D,     1'b0,32'h0};
    tbl[7]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1, 2'b10,2'b10, 1'b1,1'b1, 32'h2000, 1'b0,32'h0, 1'b1,D};
    tbl[8]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b10,2'b10, 1'b0,1'b0, 32'h2000, 1'b0,32'h0, 1'b0,D};
    tbl[9]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b01,2'b01, 1'b1,1'b1, 32'h1000, 1'b0,D,     1'b0,32'h0};
    tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b01, 1'b0,1'b0, 32'h1000, 1'b0,D,     1'b0,32'h0};
    tbl[11] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 2'b00,2'b00, 1'b0,1'b0, 32'h0,    1'b0,32'h0, 1'b0,32'h0};
    tbl[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b01, 1'b0,1'b0, 32'h2000, 1'b0,32'h0, 1'b0,D};
    tbl[13] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00, 1'b0,1'b0, 32'h0,    1'b0,32'h0, 1'b0,32'h0};

    // Reset state after two edges with rst low
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rr", act_a(), '0);
    chk("reset_fp", act_b(), '0);

    // Vector table: single master, RR tie and handovers, fixed vs RR tie
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; m_cyc = {tbl[i].c1, tbl[i].c0}; m_stb = {tbl[i].s1, tbl[i].s0};
      s_ack = tbl[i].ack; s_err = 1'b0; s_rty = 1'b0;
      #1;
      chk($sformatf("vec%0d", i),
          {38'b0, a_grant, b_grant, a_wbs_cyc, a_wbs_stb, a_wbs_adr,
           a_m0_ack, a_m0_dat, a_m1_ack, a_m1_dat, a_m0_err},
          {38'b0, tbl[i].g, tbl[i].fg, tbl[i].wcyc, tbl[i].wstb, tbl[i].adr,
           tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1, 1'b0});
    end

    // Watchdog: slave silent, ERR exactly in the 4th granted strobe cycle
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 0, 0, 0);
      chk($sformatf("to_err%0d", i), a_m0_err, (i == 3));
      chk($sformatf("to_stb%0d", i), a_wbs_stb, (i != 3));
      chk($sformatf("fp_noerr%0d", i), b_m0_err, 1'b0);
    end
    drive(1, 0, 0, 0, 0, 0);
    // Ack in the 4th cycle wins over the watchdog
    drive(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 0, 0, (i == 3));
      chk($sformatf("to_ack%0d", i), a_m0_ack, (i == 3));
      chk($sformatf("to_ackerr%0d", i), a_m0_err, 1'b0);
    end
    drive(1, 0, 0, 0, 0, 0);

    // Lock: M1 owns the bus for 8 acked transfers while M0 waits
    drive(1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 1, 1, 1, 1);
      chk($sformatf("lock_g%0d", i), {a_grant, b_grant}, 4'b1010);
      chk($sformatf("lock_ack%0d", i), {a_m0_ack, a_m1_ack, b_m0_ack, b_m1_ack}, 4'b0101);
    end

    // Reset while in G1, then first tie after release goes to master 0
    drive(0, 1, 1, 1, 1, 0);
    drive(0, 1, 1, 1, 1, 0);
    chk("rstmid_rr", act_a(), '0);
    chk("rstmid_fp", act_b(), '0);
    drive(1, 1, 1, 1, 1, 0);
    drive(1, 1, 1, 1, 1, 0);
    chk("rst_tie", {a_grant, b_grant}, 4'b0101);
    drive(1, 0, 0, 0, 0, 0);

    // Randomized traffic against the reference model
    resp_pct = 40;
    for (int i = 0; i < 1200; i++) begin
      if (i % 50 == 0) begin
        case ($urandom_range(0, 2))
          0:       resp_pct = 0;
          1:       resp_pct = 10;
          default: resp_pct = 40;
        endcase
      end
      @(negedge clk);
      rst = ($urandom_range(0, 149) != 0);
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 7) == 0) m_cyc[m] = ~m_cyc[m];
        m_stb[m] = m_cyc[m] & ($urandom_range(0, 99) < 85);
        m_adr[m] = $urandom;
        m_dat[m] = $urandom;
        m_we[m]  = 1'($urandom_range(0, 1));
        m_sel[m] = 4'($urandom_range(0, 15));
      end
      s_dat = $urandom;
      s_ack = ($urandom_range(0, 99) < resp_pct);
      s_err = ($urandom_range(0, 39) == 0);
      s_rty = ($urandom_range(0, 39) == 0);
      #1;
      model_check();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
